wb_vis_byte_reader: RTL and testbench
=====================================

Name: wb_vis_byte_reader

Overview:
Wishbone read-only slave that serialises wide complex correlator visibilities onto an 8-bit host bus (SPI/UART bridge side). It generalises the fixed 32-bit real/imag byte mux to a configurable component width, component count and byte order. A one-record line buffer with optional next-record prefetch sits in front of a fixed-latency visibility memory read port. Wait-state signalling covers memory misses.

Parameters:
WIDTH, 32, bits per component; multiple of 8; BYTES=WIDTH/8.
COMPS, 2, components per visibility (0=real, 1=imag, ...); RB=COMPS*BYTES must be a power of 2; LB=log2(RB).
VBITS, 10, visibility index width.
MSB_FIRST, 1, 1: byte 0 of a component is its MS byte; 0: LS byte first.
MEM_LAT, 1, cycles from mem_rd_o to valid mem_dat_i (>=1).
PREFETCH, 1, 1: fetch the next record after the last byte of a record is acked.

Ports:
clock  in  1  bus clock.
reset_n  in  1  asynchronous active-low reset.
cyc_i  in  1  Wishbone cycle.
stb_i  in  1  Wishbone strobe (classic: held until ack/err).
we_i  in  1  write enable (writes unsupported).
adr_i  in  VBITS+LB  {visibility index, byte offset}.
ack_o  out  1  read acknowledge, 1-cycle pulse.
wat_o  out  1  wait: request accepted, data pending.
err_o  out  1  error pulse for write attempts.
dat_o  out  8  read byte, registered.
inval_i  in  1  invalidate line buffer (bank swap).
mem_rd_o  out  1  memory read strobe, 1-cycle pulse.
mem_adr_o  out  VBITS  memory record index.
mem_dat_i  in  COMPS*WIDTH  record; component c at bits [(c+1)*WIDTH-1 : c*WIDTH].
fetch_cnt_o  out  16  demand-miss count, saturating at 0xFFFF.

Behaviour:
- Reset (async, reset_n=0): ack_o=wat_o=err_o=mem_rd_o=0, dat_o=0, mem_adr_o=0, fetch_cnt_o=0, line invalid, state IDLE. Takes effect mid-fetch; in-flight data is discarded.
- States: IDLE, FETCH (demand miss), PREF (prefetch in flight), RESP (ack/err cycle).
- Accept: in IDLE with cyc_i&stb_i&~ack_o&~err_o sampled at edge n. A strobe seen in the ack cycle is never a new request.
- Write (we_i=1): err_o=1 at n+1 for 1 cycle. No memory access, no ack.
- Hit (line valid and tag==adr_i index): dat_o and ack_o=1 at n+1. Latency 1.
- Miss: mem_rd_o=1 and mem_adr_o=index at n+1. mem_dat_i is captured into the line at n+1+MEM_LAT; tag set, valid=1. dat_o and ack_o at n+2+MEM_LAT. wat_o=1 from n+1 through n+1+MEM_LAT. fetch_cnt_o increments once per miss.
- Byte select: b=offset; c=b/BYTES; k=b%BYTES. MSB_FIRST=1 selects bits [(c*WIDTH)+WIDTH-1-8k -: 8]; MSB_FIRST=0 selects [(c*WIDTH)+8k +: 8].
- Prefetch: PREFETCH=1 and ack of offset RB-1 at cycle m -> mem_rd_o at m+1 with index+1 (mod 2^VBITS). The line is refilled at m+1+MEM_LAT and not counted in fetch_cnt_o. A request arriving during PREF is held (wat_o=1 from the accept edge) until the fill, then evaluated as hit/miss against the new line.
- inval_i: valid cleared at the next edge. During FETCH, the pending request is still served from fetched data, but the line is left invalid. During PREF, fill data is discarded. inval_i takes priority over a simultaneous fill.
- cyc_i dropped during FETCH: fetch completes and fills the line; no ack issued.
- Never two outstanding memory reads; mem_rd_o never asserted in consecutive cycles.

Test Plan:
- Reset then read adr {5,0}, mem[5]={imag 0x11223344, real 0xA1B2C3D4}, MEM_LAT=1 -> mem_rd_o at n+1 with mem_adr_o=5; ack at n+3 with dat_o=0xA1; fetch_cnt_o=1.
- Follow-on reads of offsets 1..7 of record 5 -> each ack 1 cycle after accept; bytes B2,C3,D4,11,22,33,44; no mem_rd_o until offset 7 is acked, then a prefetch with mem_adr_o=6.
- Read {6,3} immediately after the prefetch issues -> wat_o held, ack after fill, dat_o = real[7:0] of mem[6]; fetch_cnt_o unchanged. Repeat with index 1023 -> prefetch wraps to 0.
- MSB_FIRST=0, WIDTH=24, COMPS=4 (RB=12 is illegal; use WIDTH=16, RB=8), offset 2 of {real 0x1234, imag 0xABCD} -> 0xCD.
- Write strobe -> err_o pulse at n+1, no ack, no mem_rd_o. Assert inval_i in the hit cycle, then re-read the same address -> miss, fetch_cnt_o +1.
- reset_n low during FETCH -> all outputs 0 immediately; subsequent read is a miss.

Source files
------------

// File: rtl/wb_vis_byte_reader.sv
// Wishbone read-only byte port over a wide visibility memory: one-record line
// buffer, demand fetch on miss, optional prefetch of the next record.
module wb_vis_byte_reader #(
    parameter int WIDTH     = 32,
    parameter int COMPS     = 2,
    parameter int VBITS     = 10,
    parameter int MSB_FIRST = 1,
    parameter int MEM_LAT   = 1,
    parameter int PREFETCH  = 1,
    localparam int BYTES = WIDTH / 8,
    localparam int RB    = COMPS * BYTES,
    localparam int LB    = $clog2(RB),
    localparam int RW    = COMPS * WIDTH,
    localparam int AW    = VBITS + LB
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [AW-1:0]    adr_i,
    output logic             ack_o,
    output logic             wat_o,
    output logic             err_o,
    output logic [7:0]       dat_o,
    input  logic             inval_i,
    output logic             mem_rd_o,
    output logic [VBITS-1:0] mem_adr_o,
    input  logic [RW-1:0]    mem_dat_i,
    output logic [15:0]      fetch_cnt_o
);

    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, PREF, RESP} state_t;

    state_t           state_q;
    logic             ack_q, wat_q, err_q, rd_q;
    logic [7:0]       dat_q;
    logic [VBITS-1:0] madr_q;
    logic [15:0]      fcnt_q;
    logic             vld_q;
    logic [VBITS-1:0] tag_q;
    logic [RW-1:0]    line_q;
    logic [CW-1:0]    cnt_q;
    logic             inv_q, drop_q, pf_q, held_q;
    logic [VBITS-1:0] hidx_q;
    logic [LB-1:0]    hoff_q;

    logic [VBITS-1:0] req_idx, p_idx, f_idx;
    logic [LB-1:0]    req_off, p_off, f_off;
    logic             req_new, hit, fill_ok, pend_v, pend_hit, go_fetch;

    function automatic logic [7:0] sel_byte(input logic [RW-1:0] rec, input logic [LB-1:0] off);
        sel_byte = '0;
        for (int c = 0; c < COMPS; c++)
            for (int k = 0; k < BYTES; k++)
                if (off == LB'(c * BYTES + k))
                    sel_byte = (MSB_FIRST != 0) ? rec[c*WIDTH + WIDTH-1 - 8*k -: 8]
                                                : rec[c*WIDTH + 8*k +: 8];
    endfunction

    function automatic logic is_last(input logic [LB-1:0] off);
        is_last = (PREFETCH != 0) && (off == LB'(RB - 1));
    endfunction

    assign req_idx = adr_i[AW-1:LB];
    assign req_off = adr_i[LB-1:0];
    // The ack/err guard keeps a strobe still held in the response cycle from re-triggering.
    assign req_new = cyc_i & stb_i & ~ack_q & ~err_q;
    assign hit     = vld_q & (tag_q == req_idx);

    // Request to evaluate at a prefetch fill: the held one, or one arriving on the fill edge.
    assign p_idx    = held_q ? hidx_q : req_idx;
    assign p_off    = held_q ? hoff_q : req_off;
    assign pend_v   = held_q ? cyc_i : (req_new & ~we_i);
    assign fill_ok  = ~inv_q & ~inval_i;
    assign pend_hit = fill_ok & (p_idx == madr_q);

    assign go_fetch = ((state_q == IDLE) & req_new & ~we_i & ~hit) |
                      ((state_q == PREF) & (cnt_q == '0) & pend_v & ~pend_hit);
    assign f_idx    = (state_q == PREF) ? p_idx : req_idx;
    assign f_off    = (state_q == PREF) ? p_off : req_off;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            wat_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            dat_q   <= '0;
            madr_q  <= '0;
            fcnt_q  <= '0;
            vld_q   <= 1'b0;
            tag_q   <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            drop_q  <= 1'b0;
            pf_q    <= 1'b0;
            held_q  <= 1'b0;
            hidx_q  <= '0;
            hoff_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rd_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_new && we_i) begin
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else if (req_new && hit) begin
                        ack_q   <= 1'b1;
                        dat_q   <= sel_byte(line_q, req_off);
                        pf_q    <= is_last(req_off);
                        hidx_q  <= req_idx;
                        state_q <= RESP;
                    end
                end
                FETCH: begin
                    if (inval_i) inv_q <= 1'b1;
                    if (!cyc_i) drop_q <= 1'b1;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        wat_q <= 1'b0;
                        if (!(inv_q || inval_i)) begin
                            line_q <= mem_dat_i;
                            tag_q  <= madr_q;
                            vld_q  <= 1'b1;
                        end
                        if (cyc_i && !drop_q) begin
                            ack_q   <= 1'b1;
                            dat_q   <= sel_byte(mem_dat_i, hoff_q);
                            pf_q    <= is_last(hoff_q);
                            state_q <= RESP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                PREF: begin
                    if (inval_i) inv_q <= 1'b1;
                    if (held_q && !cyc_i) begin
                        held_q <= 1'b0;
                        wat_q  <= 1'b0;
                    end
                    if (!held_q && req_new && we_i) begin
                        err_q <= 1'b1;
                    end else if (!held_q && req_new && cnt_q != '0) begin
                        held_q <= 1'b1;
                        hidx_q <= req_idx;
                        hoff_q <= req_off;
                        wat_q  <= 1'b1;
                    end
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        held_q <= 1'b0;
                        wat_q  <= 1'b0;
                        if (fill_ok) begin
                            line_q <= mem_dat_i;
                            tag_q  <= madr_q;
                            vld_q  <= 1'b1;
                        end
                        if (pend_v && pend_hit) begin
                            ack_q   <= 1'b1;
                            dat_q   <= sel_byte(mem_dat_i, p_off);
                            pf_q    <= is_last(p_off);
                            hidx_q  <= p_idx;
                            state_q <= RESP;
                        end else if (!go_fetch) begin
                            state_q <= IDLE;
                        end
                    end
                end
                RESP: begin
                    if (pf_q) begin
                        pf_q    <= 1'b0;
                        rd_q    <= 1'b1;
                        madr_q  <= hidx_q + VBITS'(1);
                        cnt_q   <= CW'(MEM_LAT);
                        inv_q   <= 1'b0;
                        held_q  <= 1'b0;
                        state_q <= PREF;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (go_fetch) begin
                rd_q    <= 1'b1;
                madr_q  <= f_idx;
                hidx_q  <= f_idx;
                hoff_q  <= f_off;
                wat_q   <= 1'b1;
                cnt_q   <= CW'(MEM_LAT);
                inv_q   <= 1'b0;
                drop_q  <= 1'b0;
                state_q <= FETCH;
                if (fcnt_q != 16'hFFFF) fcnt_q <= fcnt_q + 16'd1;
            end
            // Last so that invalidate wins over a fill on the same edge.
            if (inval_i) vld_q <= 1'b0;
        end
    end

    assign ack_o       = ack_q;
    assign wat_o       = wat_q;
    assign err_o       = err_q;
    assign dat_o       = dat_q;
    assign mem_rd_o    = rd_q;
    assign mem_adr_o   = madr_q;
    assign fetch_cnt_o = fcnt_q;

endmodule

// File: tb/tb_wb_vis_byte_reader.sv
// Directed bench for wb_vis_byte_reader: default build plus a 16-bit x4, LS-first,
// two-cycle-latency, no-prefetch build; read bytes are checked through queues.
module tb_wb_vis_byte_reader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        cyc, stb, we, inval;
    logic [12:0] adr;
    logic        ack, wat, err, mem_rd;
    logic [7:0]  dat;
    logic [9:0]  madr;
    logic [63:0] mdat;
    logic [15:0] fcnt;

    logic        cyc2, stb2, we2, inval2;
    logic [6:0]  adr2;
    logic        ack2, wat2, err2, mem_rd2;
    logic [7:0]  dat2;
    logic [3:0]  madr2;
    logic [63:0] mdat2, p2a;
    logic [15:0] fcnt2;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int rdc1 = 0, rdc2 = 0;
    logic [9:0] rda1;
    logic prev1 = 1'b0, prev2 = 1'b0;
    int r0, f0;
    logic [7:0] b5 [8];

    localparam logic [63:0] JUNK = 64'h5A5A_5A5A_5A5A_5A5A;

    wb_vis_byte_reader dut (
        .clock(clock), .reset_n(reset_n), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
        .ack_o(ack), .wat_o(wat), .err_o(err), .dat_o(dat), .inval_i(inval),
        .mem_rd_o(mem_rd), .mem_adr_o(madr), .mem_dat_i(mdat), .fetch_cnt_o(fcnt)
    );

    wb_vis_byte_reader #(.WIDTH(16), .COMPS(4), .VBITS(4), .MSB_FIRST(0), .MEM_LAT(2), .PREFETCH(0)) dut2 (
        .clock(clock), .reset_n(reset_n), .cyc_i(cyc2), .stb_i(stb2), .we_i(we2), .adr_i(adr2),
        .ack_o(ack2), .wat_o(wat2), .err_o(err2), .dat_o(dat2), .inval_i(inval2),
        .mem_rd_o(mem_rd2), .mem_adr_o(madr2), .mem_dat_i(mdat2), .fetch_cnt_o(fcnt2)
    );

    function automatic logic [63:0] f1(input logic [9:0] i);
        if (i == 10'd5) return 64'h11223344_A1B2C3D4;
        return {16'hF00D, 6'b0, i, 16'hBEEF, 6'b0, i};
    endfunction

    function automatic logic [63:0] f2(input logic [3:0] i);
        return {16'h5566, 16'h7788, 16'hABCD, 12'h123, i};
    endfunction

    // Memory models: data valid MEM_LAT cycles after the read strobe, junk otherwise.
    always @(posedge clock) mdat <= mem_rd ? f1(madr) : JUNK;
    always @(posedge clock) begin
        p2a   <= mem_rd2 ? f2(madr2) : JUNK;
        mdat2 <= p2a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (ack) begin
            chk("ack1_pending", {31'b0, q1.size() != 0}, 1);
            if (q1.size() != 0) chk("dat1", dat, q1.pop_front());
        end
        if (ack2) begin
            chk("ack2_pending", {31'b0, q2.size() != 0}, 1);
            if (q2.size() != 0) chk("dat2", dat2, q2.pop_front());
        end
        if (mem_rd) begin
            rdc1++;
            rda1 = madr;
            chk("rd1_gap", prev1, 0);
        end
        if (mem_rd2) begin
            rdc2++;
            chk("rd2_gap", prev2, 0);
        end
        prev1 = mem_rd;
        prev2 = mem_rd2;
    end

    task automatic rd(input int idx, input int off, input int exp_lat, input int exp_wat, input logic [7:0] eb);
        int k, w;
        k = 0;
        w = 0;
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we = 1'b0;
        adr = {idx[9:0], off[2:0]};
        q1.push_back(eb);
        do begin
            @(negedge clock);
            k++;
            if (wat) w++;
        end while (!ack && k < 40);
        cyc = 1'b0; stb = 1'b0;
        chk($sformatf("lat1 %0d.%0d", idx, off), k, exp_lat);
        chk($sformatf("wat1 %0d.%0d", idx, off), w, exp_wat);
    endtask

    task automatic rd2(input int idx, input int off, input int exp_lat, input int exp_wat, input logic [7:0] eb);
        int k, w;
        k = 0;
        w = 0;
        @(negedge clock);
        cyc2 = 1'b1; stb2 = 1'b1; we2 = 1'b0;
        adr2 = {idx[3:0], off[2:0]};
        q2.push_back(eb);
        do begin
            @(negedge clock);
            k++;
            if (wat2) w++;
        end while (!ack2 && k < 40);
        cyc2 = 1'b0; stb2 = 1'b0;
        chk($sformatf("lat2 %0d.%0d", idx, off), k, exp_lat);
        chk($sformatf("wat2 %0d.%0d", idx, off), w, exp_wat);
    endtask

    initial begin
        reset_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; inval = 1'b0; adr = '0;
        cyc2 = 1'b0; stb2 = 1'b0; we2 = 1'b0; inval2 = 1'b0; adr2 = '0;
        b5 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h11, 8'h22, 8'h33, 8'h44};
        repeat (2) @(negedge clock);
        chk("rst_ack", ack, 0);
        chk("rst_wat", wat, 0);
        chk("rst_err", err, 0);
        chk("rst_rd", mem_rd, 0);
        chk("rst_dat", dat, 0);
        chk("rst_madr", madr, 0);
        chk("rst_fcnt", fcnt, 0);
        chk("rst_fcnt2", fcnt2, 0);
        reset_n = 1'b1;

        // Demand miss, then hits across the record, then prefetch of the next one.
        rd(5, 0, 3, 2, 8'hA1);
        chk("miss_fcnt", fcnt, 1);
        chk("miss_rdcnt", rdc1, 1);
        chk("miss_adr", rda1, 5);
        for (int o = 1; o < 8; o++) begin
            rd(5, o, 1, 0, b5[o]);
            if (o == 6) chk("no_early_pf", rdc1, 1);
        end
        rd(6, 3, 2, 1, 8'h06);
        chk("pf_rdcnt", rdc1, 2);
        chk("pf_adr", rda1, 6);
        chk("pf_fcnt", fcnt, 1);

        // Prefetch wraps from the top index to 0.
        rd(1023, 0, 3, 2, 8'hBE);
        chk("wrap_fcnt_miss", fcnt, 2);
        rd(1023, 7, 1, 0, 8'hFF);
        rd(0, 1, 2, 1, 8'hEF);
        chk("wrap_adr", rda1, 0);
        chk("wrap_fcnt", fcnt, 2);
        chk("wrap_rdcnt", rdc1, 4);

        // Write attempt: error pulse only.
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {10'd9, 3'd0};
        r0 = rdc1;
        @(negedge clock);
        chk("err_pulse", err, 1);
        chk("err_noack", ack, 0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clock);
        chk("err_once", err, 0);
        repeat (3) @(negedge clock);
        chk("err_nomem", rdc1, r0);

        // Invalidate in the ack cycle of a hit forces the next read to miss.
        rd(0, 1, 1, 0, 8'hEF);
        inval = 1'b1;
        @(negedge clock);
        inval = 1'b0;
        rd(0, 1, 3, 2, 8'hEF);
        chk("inval_fcnt", fcnt, 3);

        // Invalidate while a prefetch is in flight discards the fill.
        rd(0, 7, 1, 0, 8'h00);
        @(negedge clock);
        inval = 1'b1;
        @(negedge clock);
        inval = 1'b0;
        r0 = rdc1;
        rd(1, 0, 3, 2, 8'hBE);
        chk("pfinv_fcnt", fcnt, 4);
        chk("pfinv_rdcnt", rdc1, r0 + 1);

        // Cycle dropped mid-fetch: no ack, but the line is filled.
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {10'd2, 3'd1};
        f0 = fcnt;
        @(negedge clock);
        cyc = 1'b0; stb = 1'b0;
        repeat (5) @(negedge clock);
        chk("drop_fcnt", fcnt, f0 + 1);
        chk("drop_wat", wat, 0);
        rd(2, 1, 1, 0, 8'hEF);

        // Asynchronous reset in the middle of a fetch.
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; adr = {10'd3, 3'd0};
        @(negedge clock);
        chk("rst_pre_rd", mem_rd, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_rd", mem_rd, 0);
        chk("arst_wat", wat, 0);
        chk("arst_ack", ack, 0);
        chk("arst_dat", dat, 0);
        chk("arst_madr", madr, 0);
        chk("arst_fcnt", fcnt, 0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        rd(3, 0, 3, 2, 8'hBE);
        chk("post_rst_fcnt", fcnt, 1);

        // LS-byte-first, 16-bit components, two-cycle memory, no prefetch.
        rd2(3, 2, 4, 3, 8'hCD);
        rd2(3, 5, 1, 0, 8'h77);
        rd2(3, 7, 1, 0, 8'h55);
        rd2(3, 0, 1, 0, 8'h33);
        repeat (4) @(negedge clock);
        chk("np_rdcnt", rdc2, 1);
        chk("np_fcnt", fcnt2, 1);

        repeat (2) @(negedge clock);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
